// File: rtl/pedido_teclado.sv
`default_nettype none
// ============================================================================
// pedido_teclado: 4x4 keypad scanner, debouncer and dose-entry FSM that
// drives maximo/inicio towards the dispenser.          Revision: 1.0
// ============================================================================
module pedido_teclado #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 20,
  parameter int INICIO_CYCLES  = 1000000
) (
  input  logic       clk_50MHz,
  input  logic       rst,
  input  logic [3:0] fila,
  output logic [3:0] columna,
  input  logic       busy,
  output logic [3:0] maximo,
  output logic       inicio,
  output logic [3:0] digito,
  output logic       error,
  output logic       tecla_valida,
  output logic [1:0] estado
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int IW = $clog2(INICIO_CYCLES + 1);

  localparam logic [SW-1:0] C_DIV_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] C_DB_MAX   = DW'(DEBOUNCE_SCANS);
  localparam logic [IW-1:0] C_INI_LAST = IW'(INICIO_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_START = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  logic [3:0]    r_fila_m, r_fila_s;
  logic [SW-1:0] r_div;
  logic [1:0]    r_col;
  logic [1:0]    r_hit_cnt;
  logic [3:0]    r_hit_code;
  logic [DW-1:0] r_press_cnt, r_rel_cnt;
  logic [3:0]    r_cand;
  logic          r_pressed;
  logic          r_evt;
  logic [3:0]    r_evt_key;
  logic [1:0]    r_state, w_next;
  logic [3:0]    r_digito, r_maximo;
  logic          r_error, r_tecla;
  logic          r_ini_active;
  logic [IW-1:0] r_ini_cnt;

  logic          w_slot_end, w_scan_end, w_scan_single;
  logic [3:0]    w_row_low;
  logic [2:0]    w_nlow, w_sum;
  logic [1:0]    w_sum_sat, w_row_idx;
  logic [3:0]    w_acc_code;
  logic [DW-1:0] w_press_next, w_rel_next;
  logic          w_is_digit, w_is_star, w_is_hash, w_acc;
  logic [3:0]    w_digit_val;

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      r_fila_m <= 4'hF;
      r_fila_s <= 4'hF;
    end else begin
      r_fila_m <= fila;
      r_fila_s <= r_fila_m;
    end
  end

  // Per-slot row evaluation; hit count saturates at 2, meaning "multi".
  assign w_slot_end = (r_div == C_DIV_LAST);
  assign w_scan_end = w_slot_end && (r_col == 2'd3);
  assign w_row_low  = ~r_fila_s;
  assign w_nlow     = {2'b00, w_row_low[0]} + {2'b00, w_row_low[1]}
                    + {2'b00, w_row_low[2]} + {2'b00, w_row_low[3]};
  assign w_sum      = {1'b0, r_hit_cnt} + w_nlow;
  assign w_sum_sat  = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
  assign w_acc_code = (w_nlow == 3'd1) ? {w_row_idx, r_col} : r_hit_code;
  assign w_scan_single = w_scan_end && (w_sum == 3'd1);

  always_comb begin
    w_row_idx = 2'd3;
    if (w_row_low[0])      w_row_idx = 2'd0;
    else if (w_row_low[1]) w_row_idx = 2'd1;
    else if (w_row_low[2]) w_row_idx = 2'd2;
  end

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      r_div      <= '0;
      r_col      <= 2'd0;
      r_hit_cnt  <= 2'd0;
      r_hit_code <= 4'd0;
    end else if (w_slot_end) begin
      r_div <= '0;
      r_col <= r_col + 2'd1;
      if (r_col == 2'd3) begin
        r_hit_cnt  <= 2'd0;
        r_hit_code <= 4'd0;
      end else begin
        r_hit_cnt  <= w_sum_sat;
        r_hit_code <= w_acc_code;
      end
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign w_press_next = (r_press_cnt != '0 && w_acc_code == r_cand)
                      ? ((r_press_cnt == C_DB_MAX) ? C_DB_MAX : r_press_cnt + 1'b1)
                      : DW'(1);
  assign w_rel_next   = (r_rel_cnt == C_DB_MAX) ? C_DB_MAX : r_rel_cnt + 1'b1;

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      r_press_cnt <= '0;
      r_rel_cnt   <= '0;
      r_cand      <= 4'd0;
      r_pressed   <= 1'b0;
      r_evt       <= 1'b0;
      r_evt_key   <= 4'd0;
    end else begin
      r_evt <= 1'b0;
      if (w_scan_single) begin
        r_rel_cnt   <= '0;
        r_press_cnt <= w_press_next;
        r_cand      <= w_acc_code;
        if (!r_pressed && w_press_next == C_DB_MAX) begin
          r_evt     <= 1'b1;
          r_evt_key <= w_acc_code;
          r_pressed <= 1'b1;
        end
      end else if (w_scan_end) begin
        r_press_cnt <= '0;
        r_rel_cnt   <= w_rel_next;
        if (w_rel_next == C_DB_MAX) r_pressed <= 1'b0;
      end
    end
  end

  // Key code is {row, col}; column 3 holds A-D, which decode to nothing.
  always_comb begin
    w_is_digit  = 1'b0;
    w_is_star   = 1'b0;
    w_is_hash   = 1'b0;
    w_digit_val = 4'd0;
    if (r_evt_key[1:0] != 2'd3) begin
      if (r_evt_key[3:2] == 2'd3) begin
        case (r_evt_key[1:0])
          2'd0:    w_is_star  = 1'b1;
          2'd1:    w_is_digit = 1'b1;
          default: w_is_hash  = 1'b1;
        endcase
      end else begin
        w_is_digit  = 1'b1;
        w_digit_val = {2'b00, r_evt_key[3:2]} * 4'd3 + {2'b00, r_evt_key[1:0]} + 4'd1;
      end
    end
  end

  assign w_acc = r_evt && (w_is_digit || w_is_star || w_is_hash) && (r_state != S_RUN);

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (w_acc && w_is_digit && w_digit_val != 4'd0) w_next = S_ARMED;
      S_ARMED:
        if (w_acc) begin
          if ((w_is_digit && w_digit_val == 4'd0) || w_is_star) w_next = S_IDLE;
          else if (w_is_hash)                                    w_next = S_START;
        end
      S_START:
        if (w_acc && w_is_star)        w_next = S_IDLE;
        else if (!r_ini_active && busy) w_next = S_RUN;
      S_RUN:
        if (!busy) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      r_digito     <= 4'd0;
      r_maximo     <= 4'd0;
      r_error      <= 1'b0;
      r_tecla      <= 1'b0;
      r_ini_active <= 1'b0;
      r_ini_cnt    <= '0;
    end else begin
      r_tecla <= w_acc;
      if (w_acc) begin
        case (r_state)
          S_IDLE:
            if (w_is_digit) begin
              r_digito <= w_digit_val;
              r_error  <= (w_digit_val == 4'd0);
            end else if (w_is_hash) begin
              r_error <= 1'b1;
            end else begin
              r_digito <= 4'd0;
              r_error  <= 1'b0;
            end
          S_ARMED:
            if (w_is_digit) begin
              r_digito <= w_digit_val;
              if (w_digit_val == 4'd0) r_error <= 1'b1;
            end else if (w_is_star) begin
              r_digito <= 4'd0;
            end else begin
              r_maximo <= r_digito;
              r_digito <= 4'd0;
            end
          default: ;
        endcase
      end
      // Start window: counts INICIO_CYCLES cycles, abortable by '*' in START.
      if (w_acc && r_state == S_ARMED && w_is_hash) begin
        r_ini_active <= 1'b1;
        r_ini_cnt    <= '0;
      end else if (w_acc && r_state == S_START && w_is_star) begin
        r_ini_active <= 1'b0;
        r_ini_cnt    <= '0;
      end else if (r_ini_active) begin
        if (r_ini_cnt == C_INI_LAST) begin
          r_ini_active <= 1'b0;
          r_ini_cnt    <= '0;
        end else begin
          r_ini_cnt <= r_ini_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    columna      = ~(4'b0001 << r_col);
    maximo       = r_maximo;
    inicio       = r_ini_active;
    digito       = r_digito;
    error        = r_error;
    tecla_valida = r_tecla;
    estado       = r_state;
  end

endmodule
`default_nettype wire

// File: tb/tb_pedido_teclado.sv
`default_nettype none
// tb_pedido_teclado: keypad-model bench with a table of key steps plus
// hand-written bounce, multi-key, busy and reset sequences.
module tb_pedido_teclado;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int INI      = 10;
  localparam int SCAN     = 4 * SCAN_DIV;

  localparam int K1 = 0,  K2 = 1,  K3 = 2,  KA = 3;
  localparam int K4 = 4,  K5 = 5,  K6 = 6;
  localparam int K7 = 8,  K8 = 9,  K9 = 10;
  localparam int KSTAR = 12, K0 = 13, KHASH = 14, KD = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       busy = 1'b0;
  logic [3:0] fila, columna, maximo, digito;
  logic       inicio, error, tecla_valida;
  logic [1:0] estado;
  logic [15:0] keys = 16'h0000;

  int passed = 0;
  int total  = 0;
  int pulses = 0;
  int ini_cycles = 0;
  int p0, i0, n;

  typedef struct {
    int key;
    int pulses;
    int estado;
    int digito;
    int error;
    int maximo;
    int ini;
  } step_t;
  step_t steps[17];
  logic [3:0] exp_cols[5];

  pedido_teclado #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB), .INICIO_CYCLES(INI)
  ) dut (
    .clk_50MHz(clk), .rst(rst), .fila(fila), .columna(columna), .busy(busy),
    .maximo(maximo), .inicio(inicio), .digito(digito), .error(error),
    .tecla_valida(tecla_valida), .estado(estado)
  );

  always #5 clk = ~clk;

  always_comb begin
    fila = 4'hF;
    for (int r = 0; r < 4; r++) fila[r] = ~|(keys[r*4 +: 4] & ~columna);
  end

  always @(negedge clk) begin
    if (tecla_valida) pulses++;
    if (inicio) ini_cycles++;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic align_scan();
    int k = 0;
    while (columna == 4'b1110 && k < 40) begin @(negedge clk); k++; end
    while (columna != 4'b1110 && k < 40) begin @(negedge clk); k++; end
    if (k >= 40) begin
      total++;
      $display("FAIL align: columna=%b never returned to 1110", columna);
    end
  endtask

  task automatic press(input int k, input int scans);
    align_scan();
    keys = 16'(1) << k;
    repeat (scans * SCAN) @(negedge clk);
    keys = 16'h0000;
    repeat (4 * SCAN) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //          key    pul st dig err max ini
    steps[0]  = '{K7,    1, 1, 7, 0, 0, 0};
    steps[1]  = '{KHASH, 1, 2, 0, 0, 7, INI};
    steps[2]  = '{KSTAR, 1, 0, 0, 0, 7, 0};
    steps[3]  = '{K5,    1, 1, 5, 0, 7, 0};
    steps[4]  = '{KSTAR, 1, 0, 0, 0, 7, 0};
    steps[5]  = '{KHASH, 1, 0, 0, 1, 7, 0};
    steps[6]  = '{KA,    0, 0, 0, 1, 7, 0};
    steps[7]  = '{K0,    1, 0, 0, 1, 7, 0};
    steps[8]  = '{KSTAR, 1, 0, 0, 0, 7, 0};
    steps[9]  = '{K6,    1, 1, 6, 0, 7, 0};
    steps[10] = '{K9,    1, 1, 9, 0, 7, 0};
    steps[11] = '{KD,    0, 1, 9, 0, 7, 0};
    steps[12] = '{K0,    1, 0, 0, 1, 7, 0};
    steps[13] = '{K1,    1, 1, 1, 0, 7, 0};
    steps[14] = '{KHASH, 1, 2, 0, 0, 1, INI};
    steps[15] = '{K5,    1, 2, 0, 0, 1, 0};
    steps[16] = '{KSTAR, 1, 0, 0, 0, 1, 0};
    exp_cols[0] = 4'b1110; exp_cols[1] = 4'b1101; exp_cols[2] = 4'b1011;
    exp_cols[3] = 4'b0111; exp_cols[4] = 4'b1110;

    repeat (3) @(negedge clk);
    check("reset columna", columna, 4'b1110);
    check("reset maximo", maximo, 0);
    check("reset inicio", inicio, 0);
    check("reset digito", digito, 0);
    check("reset error", error, 0);
    check("reset tecla_valida", tecla_valida, 0);
    check("reset estado", estado, 0);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("columna slot %0d", i), columna, exp_cols[i]);
      repeat (SCAN_DIV) @(negedge clk);
    end

    for (int i = 0; i < 17; i++) begin
      p0 = pulses; i0 = ini_cycles;
      press(steps[i].key, 3);
      check($sformatf("step%0d pulses", i), pulses - p0, steps[i].pulses);
      check($sformatf("step%0d estado", i), estado, steps[i].estado);
      check($sformatf("step%0d digito", i), digito, steps[i].digito);
      check($sformatf("step%0d error", i), error, steps[i].error);
      check($sformatf("step%0d maximo", i), maximo, steps[i].maximo);
      check($sformatf("step%0d inicio cycles", i), ini_cycles - i0, steps[i].ini);
    end

    // Bouncing '3': alternating with no key, then stable.
    p0 = pulses;
    align_scan();
    for (int i = 0; i < 5; i++) begin
      keys = (i % 2 == 0) ? (16'(1) << K3) : 16'h0000;
      repeat (SCAN) @(negedge clk);
    end
    keys = 16'(1) << K3;
    repeat (3 * SCAN) @(negedge clk);
    keys = 16'h0000;
    repeat (4 * SCAN) @(negedge clk);
    check("bounce pulses", pulses - p0, 1);
    check("bounce digito", digito, 3);
    check("bounce estado", estado, 1);
    press(KSTAR, 3);
    check("clear estado", estado, 0);

    // Two keys in different columns held together.
    p0 = pulses;
    align_scan();
    keys = (16'(1) << K4) | (16'(1) << K8);
    repeat (10 * SCAN) @(negedge clk);
    keys = 16'h0000;
    repeat (4 * SCAN) @(negedge clk);
    check("multi pulses", pulses - p0, 0);
    check("multi estado", estado, 0);
    check("multi digito", digito, 0);

    // Confirmed '2' with busy handshake; keys in RUN ignored.
    press(K2, 3);
    i0 = ini_cycles;
    press(KHASH, 3);
    check("dose2 estado START", estado, 2);
    check("dose2 maximo", maximo, 2);
    check("dose2 inicio cycles", ini_cycles - i0, INI);
    busy = 1'b1;
    repeat (2) @(negedge clk);
    check("busy estado RUN", estado, 3);
    p0 = pulses;
    press(KSTAR, 3);
    press(K5, 3);
    check("run pulses", pulses - p0, 0);
    check("run estado", estado, 3);
    check("run digito", digito, 0);
    check("run maximo", maximo, 2);
    busy = 1'b0;
    repeat (2) @(negedge clk);
    check("busy low estado IDLE", estado, 0);
    check("idle maximo held", maximo, 2);

    // Confirmed '9', busy pulse during inicio, reset on 5th inicio cycle.
    press(K9, 3);
    align_scan();
    keys = 16'(1) << KHASH;
    n = 0;
    while (!inicio && n < 6 * SCAN) begin @(negedge clk); n++; end
    check("dose9 inicio rise", inicio, 1);
    keys = 16'h0000;
    busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    busy = 1'b0;
    @(negedge clk);
    check("dose9 busy ignored estado", estado, 2);
    check("dose9 inicio still high", inicio, 1);
    check("dose9 maximo", maximo, 9);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("async reset inicio", inicio, 0);
    check("async reset columna", columna, 4'b1110);
    check("async reset maximo", maximo, 0);
    check("async reset digito", digito, 0);
    check("async reset error", error, 0);
    check("async reset tecla_valida", tecla_valida, 0);
    check("async reset estado", estado, 0);
    @(negedge clk);
    rst = 1'b1;
    i0 = ini_cycles;
    repeat (4 * SCAN) @(negedge clk);
    check("post reset no start", ini_cycles - i0, 0);
    check("post reset estado", estado, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pedido_teclado.md
# pedido_teclado

Order-entry front end for the grain dispenser. It scans the 4x4 membrane keypad, debounces it, and accepts a single-digit dose (1..9 cycles). On confirmation it presents the dose on `maximo` and issues the `inicio` start/counter-reset to the dispensing controller. It sits directly upstream of the principal dispenser block, which consumes `maximo` and `inicio` and reports activity back on `busy`.

## Interface
Parameters:
- `SCAN_DIV`, 50000: clk cycles per column slot (1 ms at 50 MHz).
- `DEBOUNCE_SCANS`, 20: consecutive identical full scans needed to accept a press or a release.
- `INICIO_CYCLES`, 1000000: `inicio` high time in clk cycles (20 ms, at least 2 periods of 100 Hz).

Ports:
- `clk_50MHz`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-low reset (0 = reset).
- `fila`, in, 4: keypad rows, active-low with pull-ups, asynchronous to clk.
- `columna`, out, 4: keypad column drive; exactly one bit low.
- `busy`, in, 1: dispenser running (1) / finished (0).
- `maximo`, out, 4: confirmed dose, binary 1..9.
- `inicio`, out, 1: start level, high for INICIO_CYCLES.
- `digito`, out, 4: pending (unconfirmed) digit, for the display.
- `error`, out, 1: the last confirm attempt was invalid.
- `tecla_valida`, out, 1: one-cycle pulse per accepted key event.
- `estado`, out, 2: FSM state, encoded IDLE=0, ARMED=1, START=2, RUN=3.

## Operation
- **Keymap** (row r, column c, 0-based):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
- **Synchronisation:** `fila` is passed through a 2-flop synchroniser before use.
- **Scanner:**
  - `columna` rotates 1110 → 1101 → 1011 → 0111 → 1110, advancing every SCAN_DIV cycles.
  - Rows are sampled on the last cycle of each slot.
  - One full scan yields a code: a single key, "none", or "multi". Two or more low row/column hits in the same scan count as "multi", which is treated as "none".
- **Debounce:**
  - A press event fires when one key code is identical for DEBOUNCE_SCANS consecutive scans while the key is released.
  - A release is registered after DEBOUNCE_SCANS consecutive "none" scans.
  - At most one event is generated per press. A held key never repeats.
  - A different key appearing without an intervening release resets the count and generates no event.
- **FSM:**
  - **IDLE:**
    - A digit 1-9 loads `digito`, clears `error`, and moves to ARMED.
    - Digit 0 loads `digito`=0, sets `error`, and stays in IDLE.
    - `#` sets `error` and stays in IDLE.
    - `*` clears `digito` and `error`.
  - **ARMED:**
    - A digit 1-9 overwrites `digito`.
    - Digit 0 sets `digito`=0, sets `error`, and returns to IDLE.
    - `*` clears `digito` and returns to IDLE.
    - `#` latches `maximo`←`digito`, clears `digito`, and moves to START.
  - **START:**
    - `inicio`=1 for exactly INICIO_CYCLES cycles.
    - After that, the FSM stays in START with `inicio`=0 until `busy`=1, then goes to RUN.
    - `*` in START aborts: `inicio`←0 immediately and the FSM returns to IDLE. `maximo` is kept.
  - **RUN:**
    - All keys are ignored, including `*`.
    - `busy` falling to 0 returns the FSM to IDLE.
    - `maximo` is held for the display.
- Keys A-D are ignored in every state, and no `tecla_valida` pulse is generated for them.
- `tecla_valida` pulses for digits, `*` and `#` whenever the FSM is in IDLE, ARMED or START.

## Timing
- **Reset values:**
  - `columna`=1110
  - `maximo`=0
  - `inicio`=0
  - `digito`=0
  - `error`=0
  - `tecla_valida`=0
  - `estado`=IDLE
  - All counters zeroed.
- **Reset mid-operation:** `inicio` drops asynchronously. No start is pending after reset is released.
- **Key event latency:** `tecla_valida` and the state update occur on the same cycle, on the clk following the sample that completes the DEBOUNCE_SCANS-th scan.
- **Confirm latency:**
  - `#` accepted at cycle N: `maximo` valid and `inicio`=1 from cycle N+1.
  - `inicio` falls at cycle N+1+INICIO_CYCLES.
- **`maximo` stability:** `maximo` changes only on a confirm transition and never while `inicio`=1 or in RUN.
- **`busy` already 1 when `inicio` ends:** the FSM enters RUN on the next cycle.
- **`busy` pulsing during `inicio`:** ignored. Only `busy` sampled after `inicio` falls counts.
- **Scan counter:** wraps modulo 4·SCAN_DIV with no dead cycles.
- **Debounce counters:** saturate at DEBOUNCE_SCANS.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_SCANS=3, INICIO_CYCLES=10, with a keypad model driving `fila` from `columna`.
- Reset released → `columna` cycles 1110/1101/1011/0111 every 4 clk cycles; `maximo`=0, `inicio`=0.
- Press "7" held for 3 scans, then "#" held for 3 scans → `tecla_valida` pulses twice; `maximo`=7; `inicio` high for exactly 10 cycles; `estado`=START.
- Sequence "5" → "*" → "#" → no start; `error`=1; `estado`=IDLE; `digito`=0.
- Press "3" bouncing (alternating with "none" every scan for 5 scans), then stable for 3 scans → exactly one event; `digito`=3.
- Press "4" and "8" simultaneously for 10 scans → no event. Confirmed "2" plus `busy` 0→1→0 → `estado` goes START→RUN→IDLE; keys pressed during RUN are ignored; `maximo` stays 2.
- Confirmed "9", then assert `rst`=0 on the 5th `inicio` cycle → `inicio` drops asynchronously; all outputs return to their reset values.
